multicycle_ctrl: RTL

- Multi-cycle control FSM for the RV32I core; sequences the instruction decoder and register file, ALU, PC and memories over several cycles per instruction.
- Drives the write-back select, register write enable, immediate select and ALU operand selects consumed by instruction_decoder.
- Handshakes with variable-latency instruction and data memories.
- Flags illegal opcodes and memory-ack timeouts.

---
 rtl/multicycle_ctrl_if.sv | 28 ++
 rtl/multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between multicycle_ctrl and the instruction/data memories.
// master = controller side (drives requests), slave = memory side (drives acks).
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic ir_we;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output ir_we,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  ir_we,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with an ack watchdog.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter logic [1:0]  RETURN_PC   = 2'b00,
    parameter logic [1:0]  ALU_RESULT  = 2'b01,
    parameter logic [1:0]  MEM_DATA    = 2'b10,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [31:0]              inst_i,
    multicycle_ctrl_if.master        mem_if,
    input  logic                     branch_taken_i,
    output logic [2:0]               imm_sel_o,
    output logic [1:0]               wd_sel_o,
    output logic                     rf_we_o,
    output logic                     alu_a_sel_o,
    output logic                     alu_b_sel_o,
    output logic [1:0]               alu_op_o,
    output logic                     pc_we_o,
    output logic                     pc_sel_o,
    output logic                     fault_o,
    output logic [2:0]               state_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]              cycle_cnt_o,
    output logic [31:0]              instret_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_PASS_B = 2'b10;

    localparam logic [8:0] TIMEOUT_LIM = ACK_TIMEOUT[8:0];
    localparam bit         WDOG_EN     = (ACK_TIMEOUT != 0);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] cnt_inc;
    logic       timeout_hit;
    logic       wait_cycle;
    logic [6:0] opc;

    // Ungated decode results; every output is forced low while reset is held.
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] imm_sel;
    logic [1:0] wd_sel;
    logic       rf_we;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       pc_we;
    logic       pc_sel;
    logic       fault;

    logic unused_inst;
    assign unused_inst = ^inst_i[31:7];

    assign opc         = inst_i[6:0];
    assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
    assign timeout_hit = WDOG_EN && (cnt_inc == TIMEOUT_LIM);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        wait_cycle = 1'b0;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        imm_sel    = IMM_I;
        wd_sel     = 2'b00;
        rf_we      = 1'b0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        alu_op     = ALU_ADD;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_if.imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_cycle = 1'b1;
                end
            end

            S_DECODE: begin
                case (opc)
                    OPC_R:                       begin imm_sel = IMM_I; state_d = S_EXEC; end
                    OPC_IALU, OPC_LOAD, OPC_JALR: begin imm_sel = IMM_I; state_d = S_EXEC; end
                    OPC_STORE:                   begin imm_sel = IMM_S; state_d = S_EXEC; end
                    OPC_BRANCH:                  begin imm_sel = IMM_B; state_d = S_EXEC; end
                    OPC_LUI:                     begin imm_sel = IMM_U; state_d = S_EXEC; end
                    OPC_JAL:                     begin imm_sel = IMM_J; state_d = S_EXEC; end
                    default:                     state_d = S_FAULT;
                endcase
            end

            S_EXEC: begin
                case (opc)
                    OPC_R: begin
                        alu_op  = ALU_FUNCT;
                        state_d = S_WB;
                    end
                    OPC_IALU: begin
                        alu_b_sel = 1'b1;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel = 1'b1;
                        state_d   = S_MEM;
                    end
                    OPC_LUI: begin
                        alu_b_sel = 1'b1;
                        alu_op    = ALU_PASS_B;
                        state_d   = S_WB;
                    end
                    OPC_JAL: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = 1'b1;
                        state_d   = S_WB;
                    end
                    OPC_JALR: begin
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = 1'b1;
                        state_d   = S_WB;
                    end
                    OPC_BRANCH: begin
                        // Not-taken still writes PC, with the pc+4 source.
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = branch_taken_i;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FAULT;
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OPC_STORE);
                if (mem_if.dmem_ack) begin
                    if (opc == OPC_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_cycle = 1'b1;
                end
            end

            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
                case (opc)
                    OPC_LOAD: begin
                        wd_sel = MEM_DATA;
                        pc_we  = 1'b1;
                    end
                    // Jumps already redirected the PC in EXEC.
                    OPC_JAL, OPC_JALR: wd_sel = RETURN_PC;
                    default: begin
                        wd_sel = ALU_RESULT;
                        pc_we  = 1'b1;
                    end
                endcase
            end

            S_FAULT: fault = 1'b1;

            default: state_d = S_FAULT;
        endcase

        if (wait_cycle) begin
            if (timeout_hit) begin
                state_d = S_FAULT;
            end else begin
                cnt_d = cnt_inc[7:0];
            end
        end
    end

    assign mem_if.imem_req = reset_n_i & imem_req;
    assign mem_if.ir_we    = reset_n_i & ir_we;
    assign mem_if.dmem_req = reset_n_i & dmem_req;
    assign mem_if.dmem_we  = reset_n_i & dmem_we;
    assign imm_sel_o       = reset_n_i ? imm_sel : 3'b000;
    assign wd_sel_o        = reset_n_i ? wd_sel : 2'b00;
    assign rf_we_o         = reset_n_i & rf_we;
    assign alu_a_sel_o     = reset_n_i & alu_a_sel;
    assign alu_b_sel_o     = reset_n_i & alu_b_sel;
    assign alu_op_o        = reset_n_i ? alu_op : 2'b00;
    assign pc_we_o         = reset_n_i & pc_we;
    assign pc_sel_o        = reset_n_i & pc_sel;
    assign fault_o         = reset_n_i & fault;
    assign state_o         = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != S_FAULT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (pc_we_o) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`endif

endmodule
